traffic_lamp_monitor: RTL and testbench

//  Consumer end of the traffic controller's 3-bit signal-state bus: decodes four head codes into lamp drives.

---
 rtl/traffic_pkg.sv | 85 ++++++++
 rtl/traffic_lamp_monitor_if.sv | 36 +++
 rtl/traffic_blink_gen.sv | 55 +++++
 rtl/traffic_lamp_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the traffic lamp monitor: head state
//               codes, lamp bit indices, fault cause codes, FSM encodings,
//               the 12-bit input bus record and lamp decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Head state codes on the controller bus
    localparam logic [2:0] RED           = 3'd0;
    localparam logic [2:0] GREEN         = 3'd1;
    localparam logic [2:0] YELLOW        = 3'd2;
    localparam logic [2:0] LEFT          = 3'd3;
    localparam logic [2:0] GREEN_TWINKLE = 3'd4;

    // Car lamp bit positions: {left_arrow, green, yellow, red}
    localparam int LAMP_RED  = 0;
    localparam int LAMP_YEL  = 1;
    localparam int LAMP_GRN  = 2;
    localparam int LAMP_LEFT = 3;

    // Walker lamp bit positions: {green, red}
    localparam int WALK_RED = 0;
    localparam int WALK_GRN = 1;

    // Fault cause codes; a lower code has priority when several hold
    localparam logic [2:0] FLT_NONE     = 3'd0;
    localparam logic [2:0] FLT_CAR_INV  = 3'd1;
    localparam logic [2:0] FLT_WALK_INV = 3'd2;
    localparam logic [2:0] FLT_CAR_BOTH = 3'd3;
    localparam logic [2:0] FLT_CONFLICT = 3'd4;
    localparam logic [2:0] FLT_WDOG     = 3'd5;

    // Monitor FSM encodings
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FILT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Snapshot of the four head codes; compared as a whole by the watchdog
    typedef struct packed {
        logic [2:0] h_car;
        logic [2:0] v_car;
        logic [2:0] h_walk;
        logic [2:0] v_walk;
    } traffic_bus_t;

    // Car head code to lamp pattern; unknown codes fall back to red
    function automatic logic [3:0] car_decode(input logic [2:0] code);
        logic [3:0] lamp;
        lamp = '0;
        case (code)
            RED:     lamp[LAMP_RED] = 1'b1;
            GREEN:   lamp[LAMP_GRN] = 1'b1;
            YELLOW:  lamp[LAMP_YEL] = 1'b1;
            LEFT: begin
                lamp[LAMP_LEFT] = 1'b1;
                lamp[LAMP_RED]  = 1'b1;
            end
            default: lamp[LAMP_RED] = 1'b1;
        endcase
        return lamp;
    endfunction

    // Walker head code to lamp pattern; twinkle gates green with the blink phase
    function automatic logic [1:0] walker_decode(input logic [2:0] code, input logic phase);
        logic [1:0] lamp;
        lamp = '0;
        case (code)
            RED:           lamp[WALK_RED] = 1'b1;
            GREEN:         lamp[WALK_GRN] = 1'b1;
            GREEN_TWINKLE: lamp[WALK_GRN] = phase;
            default:       lamp[WALK_RED] = 1'b1;
        endcase
        return lamp;
    endfunction

    // Walker heads only ever carry red, green or twinkle
    function automatic logic walker_code_ok(input logic [2:0] code);
        return (code == RED) || (code == GREEN) || (code == GREEN_TWINKLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_lamp_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lamp_monitor_if
// Description : Signal-state bus from the traffic controller plus the lamp
//               drive and fault status returned by the monitor.
//               master = controller/test side, slave = lamp monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_lamp_monitor_if;
    logic [2:0] i_h_car_traffic;
    logic [2:0] i_v_car_traffic;
    logic [2:0] i_h_walker_traffic;
    logic [2:0] i_v_walker_traffic;
    logic       i_fault_clr;
    logic [3:0] o_h_car_lamp;
    logic [3:0] o_v_car_lamp;
    logic [1:0] o_h_walker_lamp;
    logic [1:0] o_v_walker_lamp;
    logic       o_fault;
    logic [2:0] o_fault_code;

    modport master (
        output i_h_car_traffic, i_v_car_traffic, i_h_walker_traffic, i_v_walker_traffic,
        output i_fault_clr,
        input  o_h_car_lamp, o_v_car_lamp, o_h_walker_lamp, o_v_walker_lamp,
        input  o_fault, o_fault_code
    );

    modport slave (
        input  i_h_car_traffic, i_v_car_traffic, i_h_walker_traffic, i_v_walker_traffic,
        input  i_fault_clr,
        output o_h_car_lamp, o_v_car_lamp, o_h_walker_lamp, o_v_walker_lamp,
        output o_fault, o_fault_code
    );
endinterface
`default_nettype wire

// File: rtl/traffic_blink_gen.sv
`default_nettype none
// ============================================================================
// Module      : traffic_blink_gen
// Description : Blink phase generator shared by walker twinkle and fault
//               flash. A counter runs 0..BLINK_HALF-1 and the phase toggles
//               on each wrap; restart forces a fresh lit half-period.
//               lamp_phase is the phase the lamps show after the next edge,
//               so registered lamps line up exactly with the phase register.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_blink_gen #(
    parameter int BLINK_HALF = 25_000_000
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic restart,
    output logic      lamp_phase
);

    localparam int              CW       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          phase;
    logic          phase_next;

    // Next counter/phase: restart wins, otherwise count and toggle on wrap
    always_comb begin
        cnt_next   = cnt + CW'(1);
        phase_next = phase;
        if (restart) begin
            cnt_next   = '0;
            phase_next = 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            phase_next = ~phase;
        end
    end

    // Counter and phase registers; reset starts in the lit half
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            phase <= phase_next;
        end
    end

    assign lamp_phase = phase_next;

endmodule
`default_nettype wire

// File: rtl/traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lamp_monitor
// Description : Consumer end of the controller's signal-state bus. Decodes
//               four head codes into lamp drives, generates twinkle blinking
//               and runs a conflict monitor that forces fail-safe flash on a
//               confirmed illegal state until cleared.
// Config      : TRAFFIC_WDOG_EN - when defined, adds the stuck-bus watchdog
//               (cause 5); when undefined WDOG_MAX is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int BLINK_HALF = 25_000_000,
    parameter int FAULT_FILT = 2,
    parameter int WDOG_MAX   = 1024
) (
    input wire logic              clk,
    input wire logic              reset_n,
    traffic_lamp_monitor_if.slave bus
);

    localparam int            FCW       = (FAULT_FILT > 1) ? $clog2(FAULT_FILT) : 1;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FAULT_FILT - 1);

    traffic_bus_t   cur;
    traffic_bus_t   walk_q;
    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [FCW-1:0] filt_cnt;
    logic [FCW-1:0] filt_nxt;
    logic [2:0]     code_q;
    logic [2:0]     code_nxt;
    logic [2:0]     cond_code;
    logic           cond_any;
    logic           wdog_hit;
    logic           wdog_clr;
    logic           car_inv;
    logic           walk_inv;
    logic           car_both;
    logic           conflict;
    logic           restart;
    logic           lamp_phase;

    assign cur.h_car  = bus.i_h_car_traffic;
    assign cur.v_car  = bus.i_v_car_traffic;
    assign cur.h_walk = bus.i_h_walker_traffic;
    assign cur.v_walk = bus.i_v_walker_traffic;

    // ---------------------------------------------------------------- blink
    // A walker head entering twinkle restarts the blink so it opens lit;
    // the fault flash keeps free-running, so no restart while in FAULT.
    assign restart = (state != ST_FAULT) &&
                     (((cur.h_walk == GREEN_TWINKLE) && (walk_q.h_walk != GREEN_TWINKLE)) ||
                      ((cur.v_walk == GREEN_TWINKLE) && (walk_q.v_walk != GREEN_TWINKLE)));

    traffic_blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink (
        .clk        (clk),
        .reset_n    (reset_n),
        .restart    (restart),
        .lamp_phase (lamp_phase)
    );

    // Previous walker codes for twinkle-entry detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            walk_q <= '0;
        end else begin
            walk_q <= cur;
        end
    end

    // ------------------------------------------------------------ conditions
    assign car_inv  = (cur.h_car > LEFT) || (cur.v_car > LEFT);
    assign walk_inv = !walker_code_ok(cur.h_walk) || !walker_code_ok(cur.v_walk);
    assign car_both = (cur.h_car != RED) && (cur.v_car != RED);
    assign conflict = ((cur.h_car != RED) && (cur.h_walk != RED)) ||
                      ((cur.v_car != RED) && (cur.v_walk != RED));

    // Lowest-numbered condition is reported when several hold
    always_comb begin
        cond_code = FLT_NONE;
        if (car_inv) begin
            cond_code = FLT_CAR_INV;
        end else if (walk_inv) begin
            cond_code = FLT_WALK_INV;
        end else if (car_both) begin
            cond_code = FLT_CAR_BOTH;
        end else if (conflict) begin
            cond_code = FLT_CONFLICT;
        end
    end

    assign cond_any = (cond_code != FLT_NONE);

    // -------------------------------------------------------------- watchdog
`ifdef TRAFFIC_WDOG_EN
    localparam int             WCW      = $clog2(WDOG_MAX + 1);
    localparam logic [WCW-1:0] WDOG_TOP = WCW'(WDOG_MAX);

    logic [WCW-1:0] wdog_cnt;
    traffic_bus_t   bus_q;

    // Count cycles of an unchanged bus, saturating; any change or a fault clear restarts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
            bus_q    <= '0;
        end else begin
            bus_q <= cur;
            if ((cur != bus_q) || wdog_clr) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != WDOG_TOP) begin
                wdog_cnt <= wdog_cnt + WCW'(1);
            end
        end
    end

    assign wdog_hit = (wdog_cnt == WDOG_TOP);
`else
    // Watchdog compiled out: never fires (WDOG_MAX is a non-negative count)
    assign wdog_hit = (WDOG_MAX < 0);
`endif

    // ------------------------------------------------------------------- FSM
    // Conditions 1-4 go through the filter; a watchdog trip skips it.
    always_comb begin
        state_nxt = state;
        filt_nxt  = filt_cnt;
        code_nxt  = code_q;
        wdog_clr  = 1'b0;
        case (state)
            ST_RUN: begin
                if (cond_any) begin
                    if (FAULT_FILT == 1) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = cond_code;
                        filt_nxt  = '0;
                    end else begin
                        state_nxt = ST_FILT;
                        filt_nxt  = FCW'(1);
                    end
                end else if (wdog_hit) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FLT_WDOG;
                end
            end
            ST_FILT: begin
                if (cond_any) begin
                    if (filt_cnt == FILT_LAST) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = cond_code;
                        filt_nxt  = '0;
                    end else begin
                        filt_nxt = filt_cnt + FCW'(1);
                    end
                end else begin
                    filt_nxt = '0;
                    if (wdog_hit) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = FLT_WDOG;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.i_fault_clr && !cond_any) begin
                    state_nxt = ST_RUN;
                    code_nxt  = FLT_NONE;
                    wdog_clr  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                code_nxt  = FLT_NONE;
                filt_nxt  = '0;
            end
        endcase
    end

    // FSM state, filter count and latched cause
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            filt_cnt <= '0;
            code_q   <= FLT_NONE;
        end else begin
            state    <= state_nxt;
            filt_cnt <= filt_nxt;
            code_q   <= code_nxt;
        end
    end

    // ----------------------------------------------------------------- lamps
    // Lamp registers follow the next state so the flash override and o_fault
    // change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.o_h_car_lamp    <= 4'b0001;
            bus.o_v_car_lamp    <= 4'b0001;
            bus.o_h_walker_lamp <= 2'b01;
            bus.o_v_walker_lamp <= 2'b01;
        end else if (state_nxt == ST_FAULT) begin
            bus.o_h_car_lamp    <= {3'b000, lamp_phase};
            bus.o_v_car_lamp    <= {3'b000, lamp_phase};
            bus.o_h_walker_lamp <= 2'b01;
            bus.o_v_walker_lamp <= 2'b01;
        end else begin
            bus.o_h_car_lamp    <= car_decode(cur.h_car);
            bus.o_v_car_lamp    <= car_decode(cur.v_car);
            bus.o_h_walker_lamp <= walker_decode(cur.h_walk, lamp_phase);
            bus.o_v_walker_lamp <= walker_decode(cur.v_walk, lamp_phase);
        end
    end

    assign bus.o_fault      = (state == ST_FAULT);
    assign bus.o_fault_code = code_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_lamp_monitor
// Description : Directed bench for traffic_lamp_monitor with BLINK_HALF=4,
//               FAULT_FILT=3, WDOG_MAX=16. Watchdog steps follow the
//               TRAFFIC_WDOG_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_lamp_monitor;
    import traffic_pkg::*;

    localparam int BH = 4;

    localparam logic [3:0] CR = 4'b0001, CG = 4'b0100, CY = 4'b0010, CL = 4'b1001;
    localparam logic [1:0] WR = 2'b01, WG = 2'b10, WOFF = 2'b00;

    typedef struct {
        string      tag;
        bit         lamps;
        logic [3:0] hc;
        logic [3:0] vc;
        logic [1:0] hw;
        logic [1:0] vw;
        logic       flt;
        logic [2:0] code;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n;
    int     cyc = 0;
    int     r_cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    exp_t   sb[$];

    traffic_lamp_monitor_if ifc ();

    traffic_lamp_monitor #(
        .BLINK_HALF (4),
        .FAULT_FILT (3),
        .WDOG_MAX   (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    // Edge counter used by the blink model
    always @(posedge clk) cyc <= cyc + 1;

    // Blink model: lit for BH edges starting at the twinkle-entry edge, then dark for BH
    function automatic bit lit_at(int n);
        return (((n - r_cyc) / BH) % 2) == 0;
    endfunction

    function automatic logic [3:0] flash(int n);
        return {3'b000, lit_at(n)};
    endfunction

    task automatic cmp(string tag, logic [3:0] got, logic [3:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic drive(logic [2:0] hc, logic [2:0] vc, logic [2:0] hw, logic [2:0] vw, logic clr);
        ifc.i_h_car_traffic    = hc;
        ifc.i_v_car_traffic    = vc;
        ifc.i_h_walker_traffic = hw;
        ifc.i_v_walker_traffic = vw;
        ifc.i_fault_clr        = clr;
    endtask

    task automatic push(string tag, bit lamps, logic [3:0] hc, logic [3:0] vc,
                        logic [1:0] hw, logic [1:0] vw, logic flt, logic [2:0] code);
        exp_t e;
        e.tag = tag; e.lamps = lamps; e.hc = hc; e.vc = vc;
        e.hw = hw; e.vw = vw; e.flt = flt; e.code = code;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            if (e.lamps) begin
                cmp({e.tag, ".h_car"}, ifc.o_h_car_lamp, e.hc);
                cmp({e.tag, ".v_car"}, ifc.o_v_car_lamp, e.vc);
                cmp({e.tag, ".h_walk"}, {2'b00, ifc.o_h_walker_lamp}, {2'b00, e.hw});
                cmp({e.tag, ".v_walk"}, {2'b00, ifc.o_v_walker_lamp}, {2'b00, e.vw});
            end
            cmp({e.tag, ".fault"}, {3'b000, ifc.o_fault}, {3'b000, e.flt});
            cmp({e.tag, ".code"}, {1'b0, ifc.o_fault_code}, {1'b0, e.code});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(RED, RED, RED, RED, 1'b0);
        #12;
        push("reset", 1, CR, CR, WR, WR, 1'b0, 3'd0);
        check_now();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal decode
        drive(GREEN, RED, RED, GREEN, 1'b0);  push("nominal", 1, CG, CR, WR, WG, 1'b0, 3'd0); tick();
        drive(YELLOW, RED, RED, GREEN, 1'b0); push("car_yel", 1, CY, CR, WR, WG, 1'b0, 3'd0); tick();
        drive(LEFT, RED, RED, GREEN, 1'b0);   push("car_left", 1, CL, CR, WR, WG, 1'b0, 3'd0); tick();
        drive(RED, LEFT, GREEN, RED, 1'b0);   push("v_left", 1, CR, CL, WG, WR, 1'b0, 3'd0); tick();

        // Twinkle: h_car alternates green/yellow to keep the bus moving
        drive(GREEN, RED, RED, GREEN, 1'b0);  push("tw_pre", 1, CG, CR, WR, WG, 1'b0, 3'd0); tick();
        r_cyc = cyc + 1;
        for (int k = 0; k < 12; k++) begin
            drive((k % 2 == 0) ? GREEN : YELLOW, RED, RED, GREEN_TWINKLE, 1'b0);
            push($sformatf("twinkle%0d", k), 1, (k % 2 == 0) ? CG : CY, CR, WR,
                 lit_at(cyc + 1) ? WG : WOFF, 1'b0, 3'd0);
            tick();
        end

        // Filter: two cycles of both-car-green do not fault, three do
        drive(GREEN, GREEN, RED, RED, 1'b0); push("filt_a1", 1, CG, CG, WR, WR, 1'b0, 3'd0); tick();
        push("filt_a2", 1, CG, CG, WR, WR, 1'b0, 3'd0); tick();
        drive(RED, GREEN, RED, RED, 1'b0);   push("filt_gone", 1, CR, CG, WR, WR, 1'b0, 3'd0); tick();
        drive(GREEN, GREEN, RED, RED, 1'b0); push("filt_b1", 1, CG, CG, WR, WR, 1'b0, 3'd0); tick();
        push("filt_b2", 1, CG, CG, WR, WR, 1'b0, 3'd0); tick();
        for (int k = 0; k < 9; k++) begin
            push($sformatf("flash%0d", k), 1, flash(cyc + 1), flash(cyc + 1), WR, WR, 1'b1, FLT_CAR_BOTH);
            tick();
        end

        // Clear is refused while the condition holds, accepted once it is gone
        drive(GREEN, GREEN, RED, RED, 1'b1);
        for (int k = 0; k < 2; k++) begin
            push("clr_refused", 1, flash(cyc + 1), flash(cyc + 1), WR, WR, 1'b1, FLT_CAR_BOTH);
            tick();
        end
        drive(RED, GREEN, RED, RED, 1'b0); push("clr_low", 1, flash(cyc + 1), flash(cyc + 1), WR, WR, 1'b1, FLT_CAR_BOTH); tick();
        drive(RED, GREEN, RED, RED, 1'b1); push("clr_ok", 1, CR, CG, WR, WR, 1'b0, 3'd0); tick();

        // Priority: invalid car code beats invalid walker code
        drive(3'd6, RED, RED, LEFT, 1'b0); push("inv_1", 1, CR, CR, WR, WR, 1'b0, 3'd0); tick();
        push("inv_2", 1, CR, CR, WR, WR, 1'b0, 3'd0); tick();
        push("inv_fault", 1, flash(cyc + 1), flash(cyc + 1), WR, WR, 1'b1, FLT_CAR_INV); tick();
        drive(RED, RED, RED, RED, 1'b1);   push("inv_clr", 1, CR, CR, WR, WR, 1'b0, 3'd0); tick();

        // Stuck bus
        drive(GREEN, RED, RED, RED, 1'b0);
        for (int k = 0; k < 15; k++) begin
            push("hold", 1, CG, CR, WR, WR, 1'b0, 3'd0);
            tick();
        end
`ifdef TRAFFIC_WDOG_EN
        for (int w = 0; w < 8 && ifc.o_fault !== 1'b1; w++) begin
            @(posedge clk);
            #1;
        end
        push("wdog_fault", 1, flash(cyc), flash(cyc), WR, WR, 1'b1, FLT_WDOG);
        check_now();
`else
        for (int k = 0; k < 8; k++) begin
            push("no_wdog", 1, CG, CR, WR, WR, 1'b0, 3'd0);
            tick();
        end
        drive(GREEN, RED, GREEN, RED, 1'b0);
        push("confl_1", 1, CG, CR, WG, WR, 1'b0, 3'd0); tick();
        push("confl_2", 1, CG, CR, WG, WR, 1'b0, 3'd0); tick();
        push("confl_fault", 1, flash(cyc + 1), flash(cyc + 1), WR, WR, 1'b1, FLT_CONFLICT); tick();
`endif

        // Asynchronous reset out of FAULT, checked before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        push("async_reset", 1, CR, CR, WR, WR, 1'b0, 3'd0);
        check_now();
        @(negedge clk);
        reset_n = 1'b1;
        drive(RED, RED, RED, RED, 1'b0);
        push("post_reset", 1, CR, CR, WR, WR, 1'b0, 3'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
